// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fc_pkg
// Purpose  : Shared defaults and FSM state encoding for the FC MAC array.
// Revision : 1.0
// ============================================================================
package fc_pkg;

    localparam int DEF_DATA_WIDTH     = 16;
    localparam int DEF_ADDR_WIDTH     = 9;
    localparam int DEF_PARALLEL_FC_PE = 32;
    localparam int DEF_FC_COLUMNS     = 32;
    localparam int DEF_ACC_WIDTH      = 40;
    localparam int DEF_FRAC_BITS      = 8;

    typedef logic [1:0] fc_state_t;

    localparam fc_state_t ST_IDLE  = 2'd0;
    localparam fc_state_t ST_RUN   = 2'd1;
    localparam fc_state_t ST_DRAIN = 2'd2;
    localparam fc_state_t ST_OUT   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/fc_mac_lane.sv
`default_nettype none
// ============================================================================
// Module   : fc_mac_lane
// Purpose  : One neuron lane: product register, accumulator, shift/saturate.
// Revision : 1.0
// ============================================================================
module fc_mac_lane
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
    parameter int FRAC_BITS  = DEF_FRAC_BITS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         load,
    input  logic                         accum,
    input  logic                         out_en,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic signed [DATA_WIDTH-1:0] weight,
    output logic        [DATA_WIDTH-1:0] out_data
);

    localparam int c_prod_width = 2 * DATA_WIDTH;
    localparam logic signed [ACC_WIDTH-1:0] c_sat_max = ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] c_sat_min = ~c_sat_max;

    logic signed [c_prod_width-1:0] r_prod;
    logic signed [ACC_WIDTH-1:0]    r_acc;
    logic signed [ACC_WIDTH-1:0]    w_shift;
    logic        [DATA_WIDTH-1:0]   w_sat;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_prod <= '0;
            r_acc  <= '0;
        end else begin
            if (load) begin
                r_prod <= in_data * weight;
            end
            // Accumulate trails the product load by one cycle.
            if (accum) begin
                r_acc <= r_acc + {{(ACC_WIDTH - c_prod_width){r_prod[c_prod_width-1]}}, r_prod};
            end
        end
    end

    assign w_shift = r_acc >>> FRAC_BITS;

    always_comb begin
        w_sat = w_shift[DATA_WIDTH-1:0];
        if (w_shift > c_sat_max) begin
            w_sat = c_sat_max[DATA_WIDTH-1:0];
        end else if (w_shift < c_sat_min) begin
            w_sat = c_sat_min[DATA_WIDTH-1:0];
        end
        out_data = out_en ? w_sat : '0;
    end

endmodule
`default_nettype wire

// File: rtl/fc_mac_array.sv
`default_nettype none
// ============================================================================
// Module   : fc_mac_array
// Purpose  : Fully-connected layer engine, parallel_fc_PE MAC lanes in lockstep.
// Revision : 1.0
// ============================================================================
module fc_mac_array
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int parallel_fc_PE = DEF_PARALLEL_FC_PE,
    parameter int fc_columns     = DEF_FC_COLUMNS,
    parameter int ACC_WIDTH      = DEF_ACC_WIDTH,
    parameter int FRAC_BITS      = DEF_FRAC_BITS
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [DATA_WIDTH-1:0]                in_data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic [ADDR_WIDTH-1:0]                address_fc,
    output logic                                 read_en_MM_fc,
    output logic                                 enable_MM_out_fc,
    input  logic [DATA_WIDTH*parallel_fc_PE-1:0] dataMainMemo_fc,
    output logic [DATA_WIDTH*parallel_fc_PE-1:0] out_data,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 busy
);

    fc_state_t             r_state;
    logic [ADDR_WIDTH-1:0] r_col_cnt;
    logic                  r_acc_en;

    logic w_run;
    logic w_hs;
    logic w_last;
    logic w_clear;

    assign w_run   = (r_state == ST_RUN);
    assign w_hs    = w_run & in_valid;
    assign w_last  = (r_col_cnt == ADDR_WIDTH'(fc_columns - 1));
    assign w_clear = (r_state == ST_IDLE) & start;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_col_cnt <= '0;
            r_acc_en  <= 1'b0;
        end else begin
            r_acc_en <= w_hs;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_col_cnt <= '0;
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Counter parks on the last column so address_fc never overruns.
                    if (w_hs) begin
                        if (w_last) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_col_cnt <= r_col_cnt + ADDR_WIDTH'(1);
                        end
                    end
                end
                ST_DRAIN: r_state <= ST_OUT;
                ST_OUT: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready         = w_run;
    assign enable_MM_out_fc = w_run;
    assign read_en_MM_fc    = w_hs;
    assign address_fc       = w_run ? r_col_cnt : '0;
    assign out_valid        = (r_state == ST_OUT);
    assign busy             = (r_state != ST_IDLE);

    for (genvar k = 0; k < parallel_fc_PE; k++) begin : g_lane
        fc_mac_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .ACC_WIDTH  (ACC_WIDTH),
            .FRAC_BITS  (FRAC_BITS)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (w_clear),
            .load     (w_hs),
            .accum    (r_acc_en),
            .out_en   (out_valid),
            .in_data  (in_data),
            .weight   (dataMainMemo_fc[k*DATA_WIDTH +: DATA_WIDTH]),
            .out_data (out_data[k*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule
`default_nettype wire
